fetch_unit: RTL and testbench

Instruction fetch stage and IF/ID pipeline register: generates the PC, issues one-at-a-time requests to instruction memory over a valid/ready handshake, and drives `INSTRD`, `PCD` and `VALIDD` into the decode stage and its control unit. It sits between instruction memory and decode. It handles decode stalls, decode flushes and taken-branch redirects from execute.

---
 rtl/fetch_unit_pkg.sv | 26 ++
 rtl/if_id_reg.sv | 60 ++++++
 rtl/fetch_unit.sv | 142 ++++++++++++++
 tb/tb_fetch_unit.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage and its IF/ID register.
`ifndef INSTR_SIZE
`define INSTR_SIZE 32
`endif

package fetch_unit_pkg;

  localparam int unsigned INSTR_SIZE_DEF = `INSTR_SIZE;
  localparam int unsigned ADDR_SIZE_DEF  = 32;

  // addi x0, x0, 0 -- the canonical bubble placed into decode.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Byte distance between consecutive instructions.
  localparam int unsigned PC_INC = 4;

  // REQ : request presented to instruction memory
  // WAIT: one request accepted, response not yet seen
  // HOLD: response parked in the skid buffer while decode is stalled
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// Pipeline stage register carrying an instruction, its PC and a valid bit.
// Priority: flush > stall > load. A flush inserts a bubble and keeps the PC.
module if_id_reg
  import fetch_unit_pkg::*;
#(
  parameter int unsigned          DATA_W   = INSTR_SIZE_DEF,
  parameter int unsigned          ADDR_W   = ADDR_SIZE_DEF,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              stall_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] instr_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic [DATA_W-1:0] instr_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic              valid_o
);

  logic [DATA_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              valid_q, valid_d;

  // Next-state selection with flush/stall/load priority.
  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (flush_i) begin
      instr_d = DATA_W'(NOP_INSTR);
      valid_d = 1'b0;
    end else if (stall_i) begin
      instr_d = instr_q;
    end else if (load_i) begin
      instr_d = instr_i;
      pc_d    = pc_i;
      valid_d = 1'b1;
    end
  end

  // Register update; reset presents a bubble at the reset PC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q <= DATA_W'(NOP_INSTR);
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign instr_o = instr_q;
  assign pc_o    = pc_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC generation, single-outstanding memory requests,
// a one-entry skid buffer for decode stalls, branch redirects with stale
// response discard, and the IF/ID register feeding decode.
//
// Handshake: a request transfers on a rising edge where IMEM_REQ_VALID and
// IMEM_REQ_READY are both high; while VALID is high and READY low the address
// holds, except for a branch redirect which may retarget it. IMEM_RESP_VALID
// is a one-cycle pulse per accepted request, returned in request order, and
// is always consumed (there is no response back-pressure).
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned INSTR_SIZE = INSTR_SIZE_DEF,
  parameter int unsigned ADDR_SIZE  = ADDR_SIZE_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  IMEM_REQ_VALID,
  output logic [ADDR_SIZE-1:0]  IMEM_REQ_ADDR,
  input  logic                  IMEM_REQ_READY,
  input  logic                  IMEM_RESP_VALID,
  input  logic [INSTR_SIZE-1:0] IMEM_RESP_DATA,
  input  logic                  STALL_D,
  input  logic                  FLUSH_D,
  input  logic                  BRN_TAKEN,
  input  logic [ADDR_SIZE-1:0]  BRN_TARGET,
  output logic [INSTR_SIZE-1:0] INSTRD,
  output logic [ADDR_SIZE-1:0]  PCD,
  output logic                  VALIDD,
  output fetch_state_e          DBG_STATE
);

  localparam logic [ADDR_SIZE-1:0]  RST_PC = ADDR_SIZE'(RESET_PC);
  localparam logic [ADDR_SIZE-1:0]  INC    = ADDR_SIZE'(PC_INC);
  localparam logic [INSTR_SIZE-1:0] NOP    = INSTR_SIZE'(NOP_INSTR);

  fetch_state_e          state_q, state_d;
  logic [ADDR_SIZE-1:0]  pc_q, pc_d;
  logic                  discard_q, discard_d;
  logic [INSTR_SIZE-1:0] skid_q, skid_d;

  logic                  load;
  logic [INSTR_SIZE-1:0] load_instr;

  // Next-state, PC, skid buffer and discard-flag logic.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    discard_d  = discard_q;
    skid_d     = skid_q;
    load       = 1'b0;
    load_instr = skid_q;

    if (BRN_TAKEN) begin
      // Redirect wins over everything, including a response this cycle.
      state_d = S_REQ;
      pc_d    = BRN_TARGET;
      skid_d  = NOP;
      unique case (state_q)
        // A request accepted on this edge will return stale data.
        S_REQ:   discard_d = IMEM_REQ_READY ? 1'b1 : (discard_q & ~IMEM_RESP_VALID);
        // Still outstanding unless its response is the one arriving now
        // (and that arriving response is not itself an older stale one).
        S_WAIT:  discard_d = discard_q | ~IMEM_RESP_VALID;
        default: discard_d = 1'b0;
      endcase
    end else begin
      unique case (state_q)
        S_REQ: begin
          // A stale response can land here right after a redirect.
          if (IMEM_RESP_VALID && discard_q) discard_d = 1'b0;
          if (IMEM_REQ_READY) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (IMEM_RESP_VALID) begin
            if (discard_q) begin
              // Drop the old-path response; the real one is still pending.
              discard_d = 1'b0;
            end else if (STALL_D) begin
              skid_d  = IMEM_RESP_DATA;
              state_d = S_HOLD;
            end else begin
              load       = 1'b1;
              load_instr = IMEM_RESP_DATA;
              pc_d       = pc_q + INC;
              state_d    = S_REQ;
            end
          end
        end
        S_HOLD: begin
          if (!STALL_D) begin
            load       = 1'b1;
            load_instr = skid_q;
            pc_d       = pc_q + INC;
            state_d    = S_REQ;
          end
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  // Fetch state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_REQ;
      pc_q      <= RST_PC;
      discard_q <= 1'b0;
      skid_q    <= NOP;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      discard_q <= discard_d;
      skid_q    <= skid_d;
    end
  end

  // The PC only advances once its instruction is loaded, so pc_q is the
  // address of whatever is being requested, awaited or held.
  assign IMEM_REQ_VALID = (state_q == S_REQ);
  assign IMEM_REQ_ADDR  = pc_q;
  assign DBG_STATE      = state_q;

  if_id_reg #(
    .DATA_W   (INSTR_SIZE),
    .ADDR_W   (ADDR_SIZE),
    .RESET_PC (RST_PC)
  ) u_if_id (
    .clk     (clk),
    .rst     (rst),
    .flush_i (FLUSH_D),
    .stall_i (STALL_D),
    .load_i  (load),
    .instr_i (load_instr),
    .pc_i    (pc_q),
    .instr_o (INSTRD),
    .pc_o    (PCD),
    .valid_o (VALIDD)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order instruction memory model.
// Memory data for address a is a ^ 32'hDEAD_0000.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        IMEM_REQ_VALID;
  logic [31:0] IMEM_REQ_ADDR;
  logic        IMEM_REQ_READY = 1'b0;
  logic        IMEM_RESP_VALID = 1'b0;
  logic [31:0] IMEM_RESP_DATA = '0;
  logic        STALL_D = 1'b0;
  logic        FLUSH_D = 1'b0;
  logic        BRN_TAKEN = 1'b0;
  logic [31:0] BRN_TARGET = '0;
  logic [31:0] INSTRD;
  logic [31:0] PCD;
  logic        VALIDD;
  fetch_state_e DBG_STATE;

  fetch_unit #(
    .RESET_PC   (32'h0000_0100),
    .INSTR_SIZE (32),
    .ADDR_SIZE  (32)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .IMEM_REQ_VALID  (IMEM_REQ_VALID),
    .IMEM_REQ_ADDR   (IMEM_REQ_ADDR),
    .IMEM_REQ_READY  (IMEM_REQ_READY),
    .IMEM_RESP_VALID (IMEM_RESP_VALID),
    .IMEM_RESP_DATA  (IMEM_RESP_DATA),
    .STALL_D         (STALL_D),
    .FLUSH_D         (FLUSH_D),
    .BRN_TAKEN       (BRN_TAKEN),
    .BRN_TARGET      (BRN_TARGET),
    .INSTRD          (INSTRD),
    .PCD             (PCD),
    .VALIDD          (VALIDD),
    .DBG_STATE       (DBG_STATE)
  );

  // ---------------- scoreboard state ----------------
  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int lat      = 1;
  logic [31:0] mq_addr[$];
  int          mq_due[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // ---------------- driver: one clock plus memory model ----------------
  task automatic cycle();
    logic        acc;
    logic [31:0] acc_addr;
    logic        consumed;
    acc      = IMEM_REQ_VALID && IMEM_REQ_READY;
    acc_addr = IMEM_REQ_ADDR;
    consumed = IMEM_RESP_VALID;
    @(posedge clk);
    #1;
    cyc++;
    if (consumed) begin
      IMEM_RESP_VALID = 1'b0;
      IMEM_RESP_DATA  = '0;
    end
    if (acc) begin
      mq_addr.push_back(acc_addr);
      mq_due.push_back(cyc + lat - 1);
    end
    if (!IMEM_RESP_VALID && mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      IMEM_RESP_VALID = 1'b1;
      IMEM_RESP_DATA  = mq_addr.pop_front() ^ 32'hDEAD_0000;
      void'(mq_due.pop_front());
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", DBG_STATE, S_REQ);
    chk("rst_req_valid", IMEM_REQ_VALID, 1'b1);
    chk("rst_addr", IMEM_REQ_ADDR, 32'h100);
    chk("rst_instrd", INSTRD, 32'h0000_0013);
    chk("rst_pcd", PCD, 32'h100);
    chk("rst_validd", VALIDD, 1'b0);
    rst = 1'b0;
    IMEM_REQ_READY = 1'b1;

    // Streaming: 0x100 then 0x104
    cycle();
    chk("s1_state_wait", DBG_STATE, S_WAIT);
    chk("s1_req_low", IMEM_REQ_VALID, 1'b0);
    cycle();
    chk("s1_instrd", INSTRD, 32'hDEAD_0100);
    chk("s1_pcd", PCD, 32'h100);
    chk("s1_validd", VALIDD, 1'b1);
    chk("s1_next_addr", IMEM_REQ_ADDR, 32'h104);

    // Ready low for 3 cycles: request held, address stable
    IMEM_REQ_READY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("nr_valid", IMEM_REQ_VALID, 1'b1);
      chk("nr_addr", IMEM_REQ_ADDR, 32'h104);
      chk("nr_instrd", INSTRD, 32'hDEAD_0100);
    end
    IMEM_REQ_READY = 1'b1;
    cycle();
    cycle();
    chk("s2_instrd", INSTRD, 32'hDEAD_0104);
    chk("s2_pcd", PCD, 32'h104);
    chk("s2_addr", IMEM_REQ_ADDR, 32'h108);

    // Stall 4 cycles while the 0x108 response arrives
    cycle();
    STALL_D = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("st_state_hold", DBG_STATE, S_HOLD);
      chk("st_no_req", IMEM_REQ_VALID, 1'b0);
      chk("st_instrd", INSTRD, 32'hDEAD_0104);
    end
    STALL_D = 1'b0;
    cycle();
    chk("st_rel_instrd", INSTRD, 32'hDEAD_0108);
    chk("st_rel_pcd", PCD, 32'h108);
    chk("st_rel_addr", IMEM_REQ_ADDR, 32'h10C);
    chk("st_rel_req", IMEM_REQ_VALID, 1'b1);
    cycle();
    cycle();
    chk("s3_instrd", INSTRD, 32'hDEAD_010C);
    chk("s3_addr", IMEM_REQ_ADDR, 32'h110);

    // Branch to 0x200 while 0x110 is outstanding (slow response)
    lat = 3;
    cycle();
    chk("br_wait", DBG_STATE, S_WAIT);
    lat = 1;
    BRN_TAKEN  = 1'b1;
    BRN_TARGET = 32'h200;
    cycle();
    BRN_TAKEN = 1'b0;
    chk("br_state_req", DBG_STATE, S_REQ);
    chk("br_addr", IMEM_REQ_ADDR, 32'h200);
    chk("br_instrd_hold", INSTRD, 32'hDEAD_010C);
    cycle();
    chk("br_wait2", DBG_STATE, S_WAIT);
    chk("br_instrd_a", INSTRD, 32'hDEAD_010C);
    cycle();
    chk("br_drop_state", DBG_STATE, S_WAIT);
    chk("br_instrd_b", INSTRD, 32'hDEAD_010C);
    cycle();
    chk("br_tgt_instrd", INSTRD, 32'hDEAD_0200);
    chk("br_tgt_pcd", PCD, 32'h200);
    chk("br_next_addr", IMEM_REQ_ADDR, 32'h204);

    // Flush together with stall as the 0x204 response is consumed
    cycle();
    FLUSH_D = 1'b1;
    STALL_D = 1'b1;
    cycle();
    chk("fl_instrd", INSTRD, 32'h0000_0013);
    chk("fl_validd", VALIDD, 1'b0);
    chk("fl_pcd", PCD, 32'h200);
    chk("fl_state_hold", DBG_STATE, S_HOLD);
    FLUSH_D = 1'b0;
    STALL_D = 1'b0;
    cycle();
    chk("fl_rel_instrd", INSTRD, 32'hDEAD_0204);
    chk("fl_rel_validd", VALIDD, 1'b1);
    chk("fl_rel_addr", IMEM_REQ_ADDR, 32'h208);

    // Redirect while request is unaccepted, then PC wrap
    IMEM_REQ_READY = 1'b0;
    BRN_TAKEN  = 1'b1;
    BRN_TARGET = 32'hFFFF_FFFC;
    cycle();
    BRN_TAKEN = 1'b0;
    chk("wr_valid", IMEM_REQ_VALID, 1'b1);
    chk("wr_addr", IMEM_REQ_ADDR, 32'hFFFF_FFFC);
    IMEM_REQ_READY = 1'b1;
    cycle();
    cycle();
    chk("wr_instrd", INSTRD, 32'h2152_FFFC);
    chk("wr_pcd", PCD, 32'hFFFF_FFFC);
    chk("wr_next_addr", IMEM_REQ_ADDR, 32'h0000_0000);

    // Branch on the same edge the request to 0x0 is accepted
    BRN_TAKEN  = 1'b1;
    BRN_TARGET = 32'h300;
    cycle();
    BRN_TAKEN = 1'b0;
    chk("ba_state", DBG_STATE, S_REQ);
    chk("ba_addr", IMEM_REQ_ADDR, 32'h300);
    cycle();
    chk("ba_wait", DBG_STATE, S_WAIT);
    chk("ba_instrd_hold", INSTRD, 32'h2152_FFFC);
    cycle();
    chk("ba_instrd", INSTRD, 32'hDEAD_0300);
    chk("ba_pcd", PCD, 32'h300);
    chk("ba_validd", VALIDD, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
